// File: rtl/key_pkg.sv
// key_pkg: shared debounce FSM state encoding and ms-to-cycles helper
package key_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_P_WAIT = 2'd1;
  localparam logic [1:0] ST_HELD   = 2'd2;
  localparam logic [1:0] ST_R_WAIT = 2'd3;
  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    P_WAIT = ST_P_WAIT,
    HELD   = ST_HELD,
    R_WAIT = ST_R_WAIT
  } key_state_e;
  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction
endpackage

// File: rtl/key_debounce_chan.sv
// key_debounce_chan: one key channel - 2-flop sync, debounce FSM, press/release pulses, toggle
// Ports: clk, rst_n (async active-low); key_i (raw, 1 = pressed);
//        pressed, press_p, release_p, toggle, long_p (all registered).
// Long-press timer only built with `define KEY_LONG_PRESS_EN; otherwise long_p is 0.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int DB_CYCLES   = 4,
`ifdef KEY_LONG_PRESS_EN
  parameter int LONG_CYCLES = 10,
`endif
  parameter bit TOGGLE_INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic pressed,
  output logic press_p,
  output logic release_p,
  output logic toggle,
  output logic long_p
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  key_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0] sync_q, sync_d;
  logic s;
  logic pressed_q, pressed_d, press_p_q, press_p_d, release_p_q, release_p_d, toggle_q, toggle_d;
  assign s = sync_q[1];
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + CW'(1);
  always_comb begin
    sync_d = {sync_q[0], key_i};
    state_d = state_q;
    cnt_d = cnt_inc;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = s ? P_WAIT : IDLE;
      end
      P_WAIT: if (!s || cnt_q == DB_LAST) begin
        state_d = s ? HELD : IDLE;
        cnt_d = '0;
      end
      HELD: if (!s) begin
        state_d = R_WAIT;
        cnt_d = '0;
      end
      R_WAIT: if (s) state_d = HELD;
        else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d = '0;
        end
      default: state_d = IDLE;
    endcase
    pressed_d = state_d == HELD || state_d == R_WAIT;
    press_p_d = state_q == P_WAIT && state_d == HELD;
    release_p_d = state_q == R_WAIT && state_d == IDLE;
    toggle_d = toggle_q ^ press_p_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sync_q <= '0;
      pressed_q <= 1'b0;
      press_p_q <= 1'b0;
      release_p_q <= 1'b0;
      toggle_q <= TOGGLE_INIT;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sync_q <= sync_d;
      pressed_q <= pressed_d;
      press_p_q <= press_p_d;
      release_p_q <= release_p_d;
      toggle_q <= toggle_d;
    end
  end
  assign pressed = pressed_q;
  assign press_p = press_p_q;
  assign release_p = release_p_q;
  assign toggle = toggle_q;
`ifdef KEY_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic long_p_q, long_p_d;
  // Timer restarts on each new press, advances only while staying in HELD and
  // freezes through an R_WAIT bounce; saturating at LONG_LAST gives one pulse per hold.
  always_comb begin
    lcnt_d = state_q == P_WAIT ? '0 :
             (state_q == HELD && state_d == HELD && lcnt_q != LONG_LAST) ? lcnt_q + LW'(1) : lcnt_q;
    long_p_d = lcnt_q != LONG_LAST && lcnt_d == LONG_LAST;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt_q <= '0;
      long_p_q <= 1'b0;
    end else begin
      lcnt_q <= lcnt_d;
      long_p_q <= long_p_d;
    end
  end
  assign long_p = long_p_q;
`else
  assign long_p = 1'b0;
`endif
endmodule

// File: rtl/key_debounce_array.sv
// key_debounce_array: NUM_KEYS independent debounced key channels with pulses and toggles
// Ports: CLK; nCLR (async active-low reset); KEY[NUM_KEYS] raw keys;
//        PRESSED, PRESS_P, RELEASE_P, TOGGLE, LONG_P [NUM_KEYS] registered outputs.
// Optional `define KEY_LONG_PRESS_EN enables LONG_P; without it LONG_P is tied 0.
module key_debounce_array
  import key_pkg::*;
#(
  parameter int NUM_KEYS    = 4,
  parameter int CLK_HZ      = 50000000,
  parameter int DEBOUNCE_MS = 20,
  parameter bit KEY_ACT_LOW = 1'b1,
  parameter bit TOGGLE_INIT = 1'b0,
  parameter int LONG_MS     = 1000
) (
  input  logic                CLK,
  input  logic                nCLR,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] PRESSED,
  output logic [NUM_KEYS-1:0] PRESS_P,
  output logic [NUM_KEYS-1:0] RELEASE_P,
  output logic [NUM_KEYS-1:0] TOGGLE,
  output logic [NUM_KEYS-1:0] LONG_P
);
  localparam int DB_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
`ifdef KEY_LONG_PRESS_EN
  localparam int LONG_CYCLES = ms_to_cycles(CLK_HZ, LONG_MS);
`endif
  if (NUM_KEYS < 1 || NUM_KEYS > 16 || DB_CYCLES < 1 || LONG_MS < 1) begin : g_bad_cfg
    $error("key_debounce_array: unsupported parameter set");
  end
  // Normalise polarity before the synchronisers so reset level 0 always means released.
  logic [NUM_KEYS-1:0] key_n;
  assign key_n = KEY_ACT_LOW ? ~KEY : KEY;
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
    key_debounce_chan #(
      .DB_CYCLES(DB_CYCLES),
`ifdef KEY_LONG_PRESS_EN
      .LONG_CYCLES(LONG_CYCLES),
`endif
      .TOGGLE_INIT(TOGGLE_INIT)
    ) u_chan (
      .clk(CLK),
      .rst_n(nCLR),
      .key_i(key_n[k]),
      .pressed(PRESSED[k]),
      .press_p(PRESS_P[k]),
      .release_p(RELEASE_P[k]),
      .toggle(TOGGLE[k]),
      .long_p(LONG_P[k])
    );
  end
endmodule
